main_cpld: RTL and testbench
============================

# main_cpld

Glue-logic CPLD for the Raven68k 68000 board: sits between the CPU bus and the memory and peripheral devices. It derives the CPU clock and generates active-low chip selects for even/odd RAM, even/odd ROM and the DUART. It also produces /DTACK and a bus-error watchdog, and encodes the DUART interrupt onto the IPL lines. After reset it forces the first eight bus cycles to ROM so the CPU can fetch its reset SSP/PC.

## Interface
Parameters:
- BOOT_CYCLES, 8, number of /AS cycles forced to ROM after reset
- BERR_TIMEOUT, 64, clk_in cycles /AS may stay low without /DTACK before /BERR

Ports:
- clk_in  in  1  board oscillator; the only clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- duart_irq  in  1  DUART interrupt request, active-low
- a7, a8, a9, a17, a21  in  1 each  CPU address bits used for decode
- as, uds, lds  in  1 each  68000 /AS, /UDS, /LDS, active-low
- e  in  1  68000 E clock; reserved, ignored
- duart_dtack  in  1  DUART /DTACK, active-low
- clk_out  out  1  CPU clock = clk_in / 2
- clk_oe  out  1  clock buffer enable, active-low
- ipl0, ipl1, ipl2  out  1 each  interrupt priority lines, active-low
- ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs  out  1 each  chip selects, active-low
- mem_decode_oe  out  1  external address decoder/buffer enable, active-low
- berr  out  1  /BERR, active-low
- dtack  out  1  /DTACK to CPU, active-low

## Operation
- Clock: clk_out toggles every clk_in rising edge. clk_oe is registered: 1 while reset is low, 0 from the first edge with reset high.
- Boot overlay:
  - boot_cnt (4 bits) counts completed bus cycles. It increments when the registered as rises (low to high, end of cycle) and saturates at BOOT_CYCLES.
  - boot = (boot_cnt < BOOT_CYCLES).
- Decode (all active-low, combinational from registered state plus bus inputs; valid only when as=0):
  - boot=1: ROM region regardless of address.
  - boot=0, a21=0: RAM.
  - boot=0, a21=1, a17=1: ROM.
  - boot=0, a21=1, a17=0: I/O. DUART is selected when a9=a8=a7=0; any other I/O address selects nothing.
- Byte lanes:
  - *_evn_cs requires uds=0; *_odd_cs requires lds=0.
  - duart_cs requires lds=0 (DUART sits on D7–D0).
- mem_decode_oe = as (low whenever a bus cycle is active).
- /DTACK:
  - RAM/ROM selected: dtack goes low on the first clk_in edge after as is sampled low (one wait state).
  - DUART selected: dtack follows duart_dtack.
  - dtack returns high on the first edge after as is sampled high.
  - Nothing selected: dtack stays high.
- /BERR:
  - A 7-bit counter runs while as=0 and dtack=1 and clears when as=1.
  - When the count reaches BERR_TIMEOUT, berr is driven low and held until as is sampled high.
- Interrupt: duart_irq is registered. When the registered value is 0, level 4 is presented (ipl2=0, ipl1=1, ipl0=1); otherwise ipl2..0=111.

## Timing
- Reset (reset=0 at an edge) sets:
  - boot_cnt=0, clk_out=0, clk_oe=1
  - dtack=1, berr=1, ipl2..0=111, watchdog=0
- While reset=0, all chip selects are forced high.
- as, uds, lds, duart_irq and duart_dtack are each registered once. Edge detection uses the current and previous registered as.
- Chip selects respond combinationally to address and strobes, gated by registered boot state. Latency from the as falling edge to chip select is combinational.
- boot_cnt changes only at cycle end, so a cycle never switches region mid-cycle. Cycles 1–8 after reset go to ROM; cycle 9 onward uses the normal map.
- Reset during an active cycle aborts it: outputs go to reset values at that edge and boot restarts at 0.
- Simultaneous as rise and watchdog expiry: the rise wins, so berr stays high.

## Test plan
- Reset, then 10 /AS pulses with a21=1, a17=0, a9..a7=000, uds=lds=0 -> cycles 1–8: rom_evn_cs=rom_odd_cs=0 and duart_cs=1. Cycles 9–10: rom_*=1 and duart_cs=0.
- After boot, a21=0, uds=0, lds=1, as=0 -> ram_evn_cs=0, ram_odd_cs=1, dtack=0 one clk_in later, dtack=1 one edge after as rises.
- After boot, a21=1, a17=0, a9..a7=101, as=0 held for 70 clk_in -> no chip select, dtack=1, berr=0 from edge 64 until as is sampled high.
- DUART access with duart_dtack held high for 10 edges then low -> dtack follows duart_dtack with one edge delay, berr stays 1.
- duart_irq=0 -> ipl2..0=011 one edge later; duart_irq=1 -> 111.
- Reset mid-cycle after 5 boot cycles -> dtack=1, clk_out=0, clk_oe=1, next 8 cycles go to ROM again.

Source files
------------

// File: rtl/main_cpld.sv
// Raven68k glue CPLD: CPU clock divide, boot-time ROM overlay, chip-select decode,
// /DTACK generation, bus-error watchdog and DUART interrupt encoding onto IPL.
module main_cpld #(
  parameter int BOOT_CYCLES  = 8,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic clk_in,
  input  logic reset,
  input  logic duart_irq,
  input  logic a7,
  input  logic a8,
  input  logic a9,
  input  logic a17,
  input  logic a21,
  input  logic as,
  input  logic uds,
  input  logic lds,
  input  logic e,
  input  logic duart_dtack,
  output logic clk_out,
  output logic clk_oe,
  output logic ipl0,
  output logic ipl1,
  output logic ipl2,
  output logic ram_evn_cs,
  output logic ram_odd_cs,
  output logic rom_evn_cs,
  output logic rom_odd_cs,
  output logic duart_cs,
  output logic mem_decode_oe,
  output logic berr,
  output logic dtack
);

  localparam logic [3:0] BOOT_MAX = 4'(BOOT_CYCLES);
  localparam logic [6:0] WD_MAX   = 7'(BERR_TIMEOUT);
  localparam logic [6:0] WD_LAST  = 7'(BERR_TIMEOUT - 1);

  logic       as_p0;
  logic       as_p1;
  logic       uds_p0;
  logic       lds_p0;
  logic       irq_p0;
  logic       duart_dtack_p0;
  logic [3:0] boot_cnt;
  logic [6:0] wd_cnt;

  logic boot;
  logic bus_on;
  logic sel_ram;
  logic sel_rom;
  logic sel_duart;
  logic mem_ack;
  logic duart_ack;
  logic unused_e;

  assign unused_e = e;

  // The E clock is not needed by any decode on this board.
  assign boot      = (boot_cnt < BOOT_MAX);
  assign sel_rom   = boot | (a21 & a17);
  assign sel_ram   = ~boot & ~a21;
  assign sel_duart = ~boot & a21 & ~a17 & ~a9 & ~a8 & ~a7;

  // Chip selects follow the live bus so the device sees /AS with no added clock.
  assign bus_on     = reset & ~as;
  assign ram_evn_cs = ~(bus_on & sel_ram & ~uds);
  assign ram_odd_cs = ~(bus_on & sel_ram & ~lds);
  assign rom_evn_cs = ~(bus_on & sel_rom & ~uds);
  assign rom_odd_cs = ~(bus_on & sel_rom & ~lds);
  assign duart_cs   = ~(bus_on & sel_duart & ~lds);

  assign mem_decode_oe = as;

  // Acknowledge decisions are made from the registered strobes.
  assign mem_ack   = (sel_ram | sel_rom) & (~uds_p0 | ~lds_p0);
  assign duart_ack = sel_duart & ~lds_p0;

  assign ipl2 = irq_p0;
  assign ipl1 = 1'b1;
  assign ipl0 = 1'b1;

  // Stage p0: input registers; p1: previous /AS for end-of-cycle detection.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      as_p0          <= 1'b1;
      as_p1          <= 1'b1;
      uds_p0         <= 1'b1;
      lds_p0         <= 1'b1;
      irq_p0         <= 1'b1;
      duart_dtack_p0 <= 1'b1;
      clk_out        <= 1'b0;
      clk_oe         <= 1'b1;
      boot_cnt       <= 4'd0;
      dtack          <= 1'b1;
      berr           <= 1'b1;
      wd_cnt         <= 7'd0;
    end else begin
      as_p0          <= as;
      as_p1          <= as_p0;
      uds_p0         <= uds;
      lds_p0         <= lds;
      irq_p0         <= duart_irq;
      duart_dtack_p0 <= duart_dtack;
      clk_out        <= ~clk_out;
      clk_oe         <= 1'b0;

      // Counting only at cycle end keeps a cycle from changing region midway.
      if (as_p0 && !as_p1 && boot)
        boot_cnt <= boot_cnt + 4'd1;

      if (as_p0)
        dtack <= 1'b1;
      else if (mem_ack)
        dtack <= 1'b0;
      else if (duart_ack)
        dtack <= duart_dtack_p0;
      else
        dtack <= 1'b1;

      // A cycle ending on the same edge as expiry clears instead of faulting.
      if (as) begin
        wd_cnt <= 7'd0;
        berr   <= 1'b1;
      end else if (dtack && (wd_cnt != WD_MAX)) begin
        wd_cnt <= wd_cnt + 7'd1;
        if (wd_cnt == WD_LAST)
          berr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_main_cpld.sv
// Bench for main_cpld: decode table, directed multi-cycle sequences and random bus
// cycles, all compared against a cycle-level behavioural model of the board glue.
module tb_main_cpld;

  localparam int BOOT_CYCLES  = 8;
  localparam int BERR_TIMEOUT = 64;

  logic clk_in = 1'b0;
  logic reset, duart_irq, a7, a8, a9, a17, a21, as, uds, lds, e, duart_dtack;
  logic clk_out, clk_oe, ipl0, ipl1, ipl2;
  logic ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs;
  logic mem_decode_oe, berr, dtack;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  main_cpld #(.BOOT_CYCLES(BOOT_CYCLES), .BERR_TIMEOUT(BERR_TIMEOUT)) dut (
    .clk_in(clk_in), .reset(reset), .duart_irq(duart_irq),
    .a7(a7), .a8(a8), .a9(a9), .a17(a17), .a21(a21),
    .as(as), .uds(uds), .lds(lds), .e(e), .duart_dtack(duart_dtack),
    .clk_out(clk_out), .clk_oe(clk_oe), .ipl0(ipl0), .ipl1(ipl1), .ipl2(ipl2),
    .ram_evn_cs(ram_evn_cs), .ram_odd_cs(ram_odd_cs),
    .rom_evn_cs(rom_evn_cs), .rom_odd_cs(rom_odd_cs), .duart_cs(duart_cs),
    .mem_decode_oe(mem_decode_oe), .berr(berr), .dtack(dtack)
  );

  always #5 clk_in = ~clk_in;

  wire [4:0] cs = {ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs};

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, want, $time);
    end
  endtask

  // Target device: 0 none, 1 RAM, 2 ROM, 3 DUART.
  function automatic int region(input bit boot, input logic [4:0] adr);
    // adr = {a21, a17, a9, a8, a7}
    if (boot) return 2;
    if (!adr[4]) return 1;
    if (adr[3]) return 2;
    if (adr[2:0] != 3'b000) return 0;
    return 3;
  endfunction

  function automatic logic [4:0] exp_cs(input logic rst_n, input logic as_n, input bit boot,
                                         input logic [4:0] adr, input logic u, input logic l);
    logic [4:0] r;
    int tgt;
    r = 5'b11111;
    tgt = region(boot, adr);
    if (rst_n && !as_n) begin
      if (tgt == 1) begin r[4] = u; r[3] = l; end
      if (tgt == 2) begin r[2] = u; r[1] = l; end
      if (tgt == 3) r[0] = l;
    end
    return r;
  endfunction

  // Behavioural model: cycles completed, waiting edges and last sampled bus state.
  int   m_cycles_done, m_wait;
  logic m_as_now, m_as_before, m_uds_s, m_lds_s, m_irq_s, m_ddt_s;
  logic m_dtack, m_berr, m_clk, m_oe, nd;
  int   tgt_m;

  always @(posedge clk_in) begin
    if (!reset) begin
      m_cycles_done = 0; m_wait = 0;
      m_as_now = 1; m_as_before = 1; m_uds_s = 1; m_lds_s = 1; m_irq_s = 1; m_ddt_s = 1;
      m_dtack = 1; m_berr = 1; m_clk = 0; m_oe = 1;
    end else begin
      tgt_m = region(m_cycles_done < BOOT_CYCLES, {a21, a17, a9, a8, a7});
      if (m_as_now) nd = 1;
      else if ((tgt_m == 1 || tgt_m == 2) && !(m_uds_s && m_lds_s)) nd = 0;
      else if (tgt_m == 3 && !m_lds_s) nd = m_ddt_s;
      else nd = 1;
      if (as) begin
        m_wait = 0; m_berr = 1;
      end else if (m_dtack && m_wait < BERR_TIMEOUT) begin
        m_wait++;
        if (m_wait == BERR_TIMEOUT) m_berr = 0;
      end
      m_dtack = nd;
      if (m_as_now && !m_as_before && m_cycles_done < BOOT_CYCLES) m_cycles_done++;
      m_as_before = m_as_now; m_as_now = as;
      m_uds_s = uds; m_lds_s = lds; m_irq_s = duart_irq; m_ddt_s = duart_dtack;
      m_clk = !m_clk; m_oe = 0;
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("mdl_cs", {3'b0, cs},
          {3'b0, exp_cs(reset, as, m_cycles_done < BOOT_CYCLES, {a21, a17, a9, a8, a7}, uds, lds)});
      chk("mdl_dtack", {7'b0, dtack}, {7'b0, m_dtack});
      chk("mdl_berr", {7'b0, berr}, {7'b0, m_berr});
      chk("mdl_ipl", {5'b0, ipl2, ipl1, ipl0}, m_irq_s ? 8'h07 : 8'h03);
      chk("mdl_clk", {6'b0, clk_out, clk_oe}, {6'b0, m_clk, m_oe});
      chk("mdl_oe", {7'b0, mem_decode_oe}, {7'b0, as});
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic do_reset();
    reset = 0; as = 1; uds = 1; lds = 1;
    step(2);
    reset = 1;
  endtask

  task automatic set_adr(input logic [4:0] v);
    {a21, a17, a9, a8, a7} = v;
  endtask

  typedef struct {
    logic [4:0] adr;
    logic       u;
    logic       l;
    logic [4:0] want;
  } vec_t;

  vec_t vt[11];
  int   len;

  initial begin
    reset = 0; duart_irq = 1; as = 1; uds = 1; lds = 1; e = 0; duart_dtack = 1;
    set_adr(5'b00000);
    @(posedge clk_in); #1;
    chk_en = 1;

    // Reset state, with a cycle attempted while held in reset.
    as = 0; uds = 0; lds = 0; step(1); #1;
    chk("rst_cs", {3'b0, cs}, 8'h1f);
    chk("rst_dtack_berr", {6'b0, dtack, berr}, 8'h03);
    chk("rst_clk", {6'b0, clk_out, clk_oe}, 8'h01);
    chk("rst_ipl", {5'b0, ipl2, ipl1, ipl0}, 8'h07);
    as = 1; step(1); reset = 1; step(1);
    chk("clk_oe_run", {7'b0, clk_oe}, 8'h00);

    // Boot overlay: ten DUART-address cycles, first eight redirected to ROM.
    set_adr(5'b10000); uds = 0; lds = 0;
    for (int i = 0; i < 10; i++) begin
      as = 0; #1;
      chk(i < BOOT_CYCLES ? "boot_rom" : "boot_done_duart", {3'b0, cs},
          i < BOOT_CYCLES ? 8'h19 : 8'h1e);
      step(3); as = 1; step(3);
    end

    // Decode table after boot; cs order {ram_e, ram_o, rom_e, rom_o, duart}.
    vt[0]  = '{5'b00000, 1'b0, 1'b0, 5'b00111};
    vt[1]  = '{5'b01111, 1'b0, 1'b1, 5'b01111};
    vt[2]  = '{5'b00000, 1'b1, 1'b0, 5'b10111};
    vt[3]  = '{5'b11000, 1'b0, 1'b0, 5'b11001};
    vt[4]  = '{5'b11101, 1'b1, 1'b0, 5'b11101};
    vt[5]  = '{5'b10000, 1'b0, 1'b0, 5'b11110};
    vt[6]  = '{5'b10000, 1'b1, 1'b0, 5'b11110};
    vt[7]  = '{5'b10000, 1'b0, 1'b1, 5'b11111};
    vt[8]  = '{5'b10001, 1'b0, 1'b0, 5'b11111};
    vt[9]  = '{5'b10100, 1'b0, 1'b0, 5'b11111};
    vt[10] = '{5'b01000, 1'b1, 1'b1, 5'b11111};
    for (int i = 0; i < 11; i++) begin
      set_adr(vt[i].adr); uds = vt[i].u; lds = vt[i].l; as = 0; #1;
      chk($sformatf("table_%0d", i), {3'b0, cs}, {3'b0, vt[i].want});
      step(2); as = 1; step(3);
    end

    // RAM even-byte cycle: one wait state, release one edge after /AS is seen high.
    set_adr(5'b00000); uds = 0; lds = 1; as = 0; #1;
    chk("ram_cs", {6'b0, ram_evn_cs, ram_odd_cs}, 8'h01);
    step(1); chk("ram_dtack_wait", {7'b0, dtack}, 8'h01);
    step(1); chk("ram_dtack_low", {7'b0, dtack}, 8'h00);
    as = 1; step(1); chk("ram_dtack_hold", {7'b0, dtack}, 8'h00);
    step(1); chk("ram_dtack_rel", {7'b0, dtack}, 8'h01);
    step(2);

    // Unmapped I/O: watchdog fires on the 64th edge with /AS low.
    set_adr(5'b10101); uds = 0; lds = 0; as = 0; #1;
    chk("unmapped_cs", {3'b0, cs}, 8'h1f);
    step(63); chk("berr_before", {7'b0, berr}, 8'h01);
    step(1);  chk("berr_edge64", {7'b0, berr}, 8'h00);
    step(6);  chk("berr_hold", {6'b0, berr, dtack}, 8'h01);
    as = 1; step(1); chk("berr_clear", {7'b0, berr}, 8'h01);
    step(2);

    // DUART with slow acknowledge.
    set_adr(5'b10000); uds = 1; lds = 0; duart_dtack = 1; as = 0;
    step(10); chk("duart_wait", {6'b0, dtack, berr}, 8'h03);
    duart_dtack = 0;
    step(1); chk("duart_dtack_sampled", {7'b0, dtack}, 8'h01);
    step(1); chk("duart_dtack_follow", {6'b0, dtack, berr}, 8'h01);
    as = 1; duart_dtack = 1; step(3);

    // Interrupt encoding.
    duart_irq = 0; #1;
    chk("ipl_not_yet", {5'b0, ipl2, ipl1, ipl0}, 8'h07);
    step(1); chk("ipl_lvl4", {5'b0, ipl2, ipl1, ipl0}, 8'h03);
    duart_irq = 1; step(1); chk("ipl_idle", {5'b0, ipl2, ipl1, ipl0}, 8'h07);

    // Reset in the middle of the sixth boot cycle restarts the overlay.
    do_reset();
    set_adr(5'b00000); uds = 0; lds = 0;
    for (int i = 0; i < 5; i++) begin as = 0; step(3); as = 1; step(3); end
    as = 0; step(2);
    chk("mid_dtack_low", {7'b0, dtack}, 8'h00);
    reset = 0; step(1); #1;
    chk("mid_rst_out", {5'b0, dtack, clk_out, clk_oe}, 8'h05);
    chk("mid_rst_cs", {3'b0, cs}, 8'h1f);
    as = 1; step(1); reset = 1;
    for (int i = 0; i < 9; i++) begin
      as = 0; #1;
      chk("reboot_map", {3'b0, cs}, i < BOOT_CYCLES ? 8'h19 : 8'h07);
      step(3); as = 1; step(3);
    end

    // Random bus cycles with occasional resets and watchdog-length stalls.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 0; step($urandom_range(1, 2)); reset = 1;
      end
      set_adr(5'($urandom));
      uds = 1'($urandom); lds = 1'($urandom);
      duart_irq = 1'($urandom); e = 1'($urandom);
      as = 0; #1;
      chk("rand_cs", {3'b0, cs},
          {3'b0, exp_cs(reset, as, m_cycles_done < BOOT_CYCLES, {a21, a17, a9, a8, a7}, uds, lds)});
      len = ($urandom_range(0, 15) == 0) ? 70 : $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        duart_dtack = 1'($urandom);
        step(1);
      end
      as = 1;
      step($urandom_range(1, 3));
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
